toeplitz_tag_verifier: RTL and testbench

//  Receive-side tag check for the authentication path. Takes one message word plus the tag received with it.

---
 rtl/toeplitz_tag_verifier.sv | 123 ++++++++++++
 tb/tb_toeplitz_tag_verifier.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/toeplitz_tag_verifier.sv
// rtl/toeplitz_tag_verifier.sv - bit-serial Toeplitz tag recompute and compare (optional debug via TOEPLITZ_VERIFY_DBG_EN)
module toeplitz_tag_verifier #(
    parameter int MSG_W = 192,
    parameter int TAG_W = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MSG_W-1:0]       ss_tdata,
    input  logic [TAG_W-1:0]       ss_tuser,
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [MSG_W+TAG_W-2:0] toeplitz_key,
    output logic                   sm_tdata,
    output logic                   sm_tvalid,
`ifdef TOEPLITZ_VERIFY_DBG_EN
    input  logic                   sm_tready,
    output logic [TAG_W-1:0]       dbg_tag,
    output logic [15:0]            dbg_fail_cnt
`else
    input  logic                   sm_tready
`endif
);

    localparam int KEY_W = MSG_W + TAG_W - 1;
    localparam int CNT_W = $clog2(MSG_W);
    localparam int KB_W  = $clog2(KEY_W);

    typedef enum logic [1:0] {
        IDLE,
        HASH,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [MSG_W-1:0]   msg_q;
    logic [TAG_W-1:0]   tag_q;
    logic [KEY_W-1:0]   key_q;
    logic [TAG_W-1:0]   acc_q;
    logic [TAG_W-1:0]   acc_d;
    logic [TAG_W-1:0]   col;
    logic [CNT_W-1:0]   cnt_q;
    logic [KB_W-1:0]    col_base;
    logic               last_bit;
    logic               in_fire;

    // Column j of the Toeplitz matrix is a TAG_W-wide window of the key ending lower as j grows
    assign col_base = KB_W'(MSG_W - 1) - KB_W'(cnt_q);
    assign col      = key_q[col_base +: TAG_W];
    assign acc_d    = msg_q[cnt_q] ? (acc_q ^ col) : acc_q;
    assign last_bit = (cnt_q == CNT_W'(MSG_W - 1));
    assign in_fire  = ss_tvalid & ss_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        case (state_q)
            IDLE: begin
                ss_tready = ~rst;
                if (ss_tvalid && !rst) begin
                    state_d = HASH;
                end
            end
            HASH: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                sm_tvalid = 1'b1;
                if (sm_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_q    <= '0;
            tag_q    <= '0;
            key_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sm_tdata <= 1'b0;
        end else if (in_fire) begin
            msg_q <= ss_tdata;
            tag_q <= ss_tuser;
            key_q <= toeplitz_key;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == HASH) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_bit) begin
                sm_tdata <= (acc_d == tag_q);
            end
        end
    end

`ifdef TOEPLITZ_VERIFY_DBG_EN
    // acc_q holds the finished hash for the whole DONE phase
    assign dbg_tag = acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_fail_cnt <= '0;
        end else if (sm_tvalid && sm_tready && !sm_tdata && (dbg_fail_cnt != 16'hFFFF)) begin
            dbg_fail_cnt <= dbg_fail_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_toeplitz_tag_verifier.sv
// tb/tb_toeplitz_tag_verifier.sv - scoreboard bench for toeplitz_tag_verifier
module tb_toeplitz_tag_verifier;

    localparam int MSG_W = 192;
    localparam int TAG_W = 40;
    localparam int KEY_W = MSG_W + TAG_W - 1;
    localparam int LAT   = MSG_W + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [MSG_W-1:0] ss_tdata = '0;
    logic [TAG_W-1:0] ss_tuser = '0;
    logic             ss_tvalid = 1'b0;
    logic             ss_tready;
    logic [KEY_W-1:0] toeplitz_key = '0;
    logic             sm_tdata;
    logic             sm_tvalid;
    logic             sm_tready = 1'b1;
`ifdef TOEPLITZ_VERIFY_DBG_EN
    logic [TAG_W-1:0] dbg_tag;
    logic [15:0]      dbg_fail_cnt;
`endif

    toeplitz_tag_verifier #(.MSG_W(MSG_W), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ss_tdata     (ss_tdata),
        .ss_tuser     (ss_tuser),
        .ss_tvalid    (ss_tvalid),
        .ss_tready    (ss_tready),
        .toeplitz_key (toeplitz_key),
        .sm_tdata     (sm_tdata),
        .sm_tvalid    (sm_tvalid),
`ifdef TOEPLITZ_VERIFY_DBG_EN
        .sm_tready    (sm_tready),
        .dbg_tag      (dbg_tag),
        .dbg_fail_cnt (dbg_fail_cnt)
`else
        .sm_tready    (sm_tready)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             exp;
        logic [TAG_W-1:0] tag;
        int               hs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   model_fail = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: latency on the rising edge of sm_tvalid, result on each sm handshake
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (sm_tvalid && !prev_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result actual=valid expected=none");
                end else if (cyc - sb[0].hs != LAT) begin
                    failures++;
                    $display("FAIL latency actual=%0d expected=%0d", cyc - sb[0].hs, LAT);
                end
            end
            if (sm_tvalid && sm_tready && sb.size() > 0) begin
                chk("sm_tdata", 64'(sm_tdata), 64'(sb[0].exp));
`ifdef TOEPLITZ_VERIFY_DBG_EN
                chk("dbg_tag", 64'(dbg_tag), 64'(sb[0].tag));
`endif
                if (!sb[0].exp) model_fail++;
                void'(sb.pop_front());
            end
            prev_valid = sm_tvalid;
        end
    end

    task automatic send(input logic [MSG_W-1:0] m, input logic [TAG_W-1:0] t,
                        input logic [KEY_W-1:0] k, input logic exp,
                        input logic [TAG_W-1:0] etag, input bit scramble);
        int n = 0;
        @(posedge clk);
        #1;
        ss_tdata     = m;
        ss_tuser     = t;
        toeplitz_key = k;
        ss_tvalid    = 1'b1;
        @(negedge clk);
        while (!ss_tready && n < 600) begin
            n++;
            @(negedge clk);
        end
        if (!ss_tready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_ready expected=ready");
            ss_tvalid = 1'b0;
            return;
        end
        sb.push_back('{exp, etag, cyc});
        @(posedge clk);
        #1;
        ss_tvalid = 1'b0;
        if (scramble) begin
            toeplitz_key = ~k;
            ss_tuser     = ~t;
            ss_tdata     = ~m;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() > 0 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    logic [MSG_W-1:0] m2;
    logic [KEY_W-1:0] k2;
    logic [KEY_W-1:0] k3;
    int               saw;
    int               n;

    initial begin
        m2 = '0;
        m2[MSG_W-1] = 1'b1;
        k2 = KEY_W'(40'hA5A5A5A5A5);
        k3 = '0;
        k3[MSG_W-1] = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ss_tready_in_rst", 64'(ss_tready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ss_tready_after_rst", 64'(ss_tready), 64'd1);
        chk("sm_tvalid_after_rst", 64'(sm_tvalid), 64'd0);
        chk("sm_tdata_after_rst", 64'(sm_tdata), 64'd0);
`ifdef TOEPLITZ_VERIFY_DBG_EN
        chk("dbg_tag_after_rst", 64'(dbg_tag), 64'd0);
        chk("dbg_fail_after_rst", 64'(dbg_fail_cnt), 64'd0);
`endif

        // Zero key always hashes to zero
        send(192'h1234, 40'h0, '0, 1'b1, 40'h0, 1'b0);
        drain("drain_t1");

        // Top message bit selects the lowest key window
        send(m2, 40'hA5A5A5A5A5, k2, 1'b1, 40'hA5A5A5A5A5, 1'b0);
        send(m2, 40'hA5A5A5A5A4, k2, 1'b0, 40'hA5A5A5A5A5, 1'b0);
        drain("drain_t2");
`ifdef TOEPLITZ_VERIFY_DBG_EN
        @(negedge clk);
        chk("dbg_fail_cnt_t2", 64'(dbg_fail_cnt), 64'(model_fail));
`endif

        // Backpressure: result holds while sm_tready is low
        sm_tready = 1'b0;
        send(m2, 40'hA5A5A5A5A5, k2, 1'b1, 40'hA5A5A5A5A5, 1'b0);
        n = 0;
        while (!sm_tvalid && n < 400) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_sm_tvalid", 64'(sm_tvalid), 64'd1);
            chk("bp_sm_tdata", 64'(sm_tdata), 64'd1);
            chk("bp_ss_tready", 64'(ss_tready), 64'd0);
        end
        @(posedge clk);
        #1;
        sm_tready = 1'b1;
        @(negedge clk);
        chk("ss_tready_at_sm_hs", 64'(ss_tready), 64'd0);
        @(negedge clk);
        chk("ss_tready_after_sm_hs", 64'(ss_tready), 64'd1);
        chk("sm_tvalid_after_sm_hs", 64'(sm_tvalid), 64'd0);
        drain("drain_t4");

        // Reset mid-HASH discards the beat
        send(m2, 40'hA5A5A5A5A5, k2, 1'b1, 40'hA5A5A5A5A5, 1'b0);
        repeat (49) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        model_fail = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        saw = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sm_tvalid) saw++;
        end
        chk("no_result_after_abort", 64'(saw), 64'd0);
        send(m2, 40'hA5A5A5A5A5, k2, 1'b1, 40'hA5A5A5A5A5, 1'b0);
        drain("drain_t5");

        // Inputs changed after capture must not matter
        send(m2, 40'hA5A5A5A5A5, k2, 1'b1, 40'hA5A5A5A5A5, 1'b1);
        drain("drain_t6");

        // Linearity with a single-bit key
        send(192'h1, 40'h1, k3, 1'b1, 40'h1, 1'b1);
        send(192'h3, 40'h3, k3, 1'b1, 40'h3, 1'b0);
        send(192'h3, 40'h1, k3, 1'b0, 40'h3, 1'b1);
        drain("drain_t3");
`ifdef TOEPLITZ_VERIFY_DBG_EN
        @(negedge clk);
        chk("dbg_fail_cnt_end", 64'(dbg_fail_cnt), 64'(model_fail));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
